// File: rtl/puzzle_regfile_p_pkg.sv
// Shared constants for the sliding-puzzle datapath: fixed register roles
// and the default start/solved boards (6 cells x 3 bits).
package puzzle_pkg;
  localparam int BOARD_IDX = 0;
  localparam int CNT_IDX   = 1;
  localparam int ORD_IDX   = 2;
  localparam int CELL_W    = 3;
  localparam int CELLS     = 6;
  localparam int BOARD_W_DEF = CELL_W * CELLS;

  localparam logic [BOARD_W_DEF-1:0] INIT_DEF = 18'b100_011_010_001_101_000;
  localparam logic [BOARD_W_DEF-1:0] GOAL_DEF = 18'b001_010_011_100_101_000;
endpackage

// File: rtl/puzzle_regfile_p_if.sv
// Register-file access bundle: one write port, NUM_RD packed read ports,
// restart strobe and the always-visible counter/order/goal outputs.
interface puzzle_regfile_p_if #(
  parameter int DATA_W = 40,
  parameter int AW     = 4,
  parameter int NUM_RD = 2
);
  logic                     we;
  logic [AW-1:0]            dst;
  logic [DATA_W-1:0]        wdata;
  logic [NUM_RD*AW-1:0]     src;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic                     restart;
  logic [DATA_W-1:0]        cnt;
  logic [DATA_W-1:0]        ord;
  logic                     comp;

  modport master (
    output we, dst, wdata, src, restart,
    input  rdata, cnt, ord, comp
  );
  modport slave (
    input  we, dst, wdata, src, restart,
    output rdata, cnt, ord, comp
  );
endinterface

// File: rtl/puzzle_regfile_p.sv
// Puzzle register file: combinational reads, one synchronous write, hardware
// move counter on board changes, registered goal flag and one-cycle restart.
module puzzle_regfile_p
  import puzzle_pkg::*;
#(
  parameter int DATA_W  = 40,
  parameter int DEPTH   = 16,
  parameter int NUM_RD  = 2,
  parameter int BOARD_W = 18,
  parameter bit BYPASS  = 1'b0,
  parameter logic [BOARD_W-1:0] INIT = BOARD_W'(INIT_DEF),
  parameter logic [BOARD_W-1:0] GOAL = BOARD_W'(GOAL_DEF)
) (
  input logic             clk,
  input logic             rst_n,
  puzzle_regfile_p_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] B_A = AW'(BOARD_IDX);
  localparam logic [AW-1:0] C_A = AW'(CNT_IDX);
  localparam logic [AW-1:0] O_A = AW'(ORD_IDX);

  logic [DATA_W-1:0] regs [DEPTH];
  logic              comp_q;
  logic [BOARD_W-1:0] board_cur, board_nxt;
  logic              board_wr, board_chg, cnt_sat, inc;

  // Shared board logic: change detect feeds the counter, next-board feeds comp.
  assign board_cur = regs[B_A][BOARD_W-1:0];
  assign board_wr  = bus.we && (bus.dst == B_A);
  assign board_chg = bus.wdata[BOARD_W-1:0] != board_cur;
  assign cnt_sat   = &regs[C_A];
  assign inc       = board_wr && board_chg && !cnt_sat;

  always_comb begin
    board_nxt = board_cur;
    if (!rst_n || bus.restart)
      board_nxt = INIT;
    else if (board_wr)
      board_nxt = bus.wdata[BOARD_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= (i == BOARD_IDX) ? DATA_W'(INIT) : '0;
    end else if (bus.restart) begin
      regs[B_A] <= DATA_W'(INIT);
      regs[C_A] <= '0;
      regs[O_A] <= '0;
    end else begin
      if (bus.we)
        regs[bus.dst] <= bus.wdata;
      // inc implies dst is the board, so it never collides with a reg1 write
      if (inc)
        regs[C_A] <= regs[C_A] + DATA_W'(1);
    end
    comp_q <= (board_nxt == GOAL);
  end

  logic [NUM_RD-1:0][DATA_W-1:0] rd;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [AW-1:0] a;
    assign a = bus.src[p*AW +: AW];
    if (BYPASS) begin : g_byp
      // Write data is forwarded only when the write will actually land.
      assign rd[p] = (bus.we && !bus.restart && rst_n && (a == bus.dst))
                     ? bus.wdata : regs[a];
    end else begin : g_nobyp
      assign rd[p] = regs[a];
    end
  end

  assign bus.rdata = rd;
  assign bus.cnt   = regs[C_A];
  assign bus.ord   = regs[O_A];
  assign bus.comp  = comp_q;
endmodule

// File: tb/tb_puzzle_regfile_p.sv
// Bench for puzzle_regfile_p: three parameterisations driven in lockstep,
// checked each cycle against an array model plus hand-computed literals.
module tb_puzzle_regfile_p;
  import puzzle_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0;
  logic        restart = 1'b0;
  logic [3:0]  dst = '0;
  logic [39:0] wdata = '0;
  logic [3:0]  src [3];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  puzzle_regfile_p_if #(.DATA_W(40), .AW(4), .NUM_RD(2)) ifa ();
  puzzle_regfile_p_if #(.DATA_W(40), .AW(4), .NUM_RD(3)) ifb ();
  puzzle_regfile_p_if #(.DATA_W(24), .AW(3), .NUM_RD(3)) ifc ();

  assign ifa.we = we;  assign ifb.we = we;  assign ifc.we = we;
  assign ifa.restart = restart; assign ifb.restart = restart; assign ifc.restart = restart;
  assign ifa.dst = dst; assign ifb.dst = dst; assign ifc.dst = dst[2:0];
  assign ifa.wdata = wdata; assign ifb.wdata = wdata; assign ifc.wdata = wdata[23:0];
  assign ifa.src = {src[1], src[0]};
  assign ifb.src = {src[2], src[1], src[0]};
  assign ifc.src = {src[2][2:0], src[1][2:0], src[0][2:0]};

  puzzle_regfile_p #(.DATA_W(40), .DEPTH(16), .NUM_RD(2), .BYPASS(1'b0))
    u_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  puzzle_regfile_p #(.DATA_W(40), .DEPTH(16), .NUM_RD(3), .BYPASS(1'b1))
    u_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
  puzzle_regfile_p #(.DATA_W(24), .DEPTH(8), .NUM_RD(3), .BYPASS(1'b0))
    u_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

  logic [39:0] act_rd [3][3];
  logic [39:0] act_cnt [3];
  logic [39:0] act_ord [3];
  logic        act_comp [3];

  assign act_rd[0][0] = ifa.rdata[39:0];
  assign act_rd[0][1] = ifa.rdata[79:40];
  assign act_rd[0][2] = '0;
  assign act_rd[1][0] = ifb.rdata[39:0];
  assign act_rd[1][1] = ifb.rdata[79:40];
  assign act_rd[1][2] = ifb.rdata[119:80];
  assign act_rd[2][0] = {16'h0, ifc.rdata[23:0]};
  assign act_rd[2][1] = {16'h0, ifc.rdata[47:24]};
  assign act_rd[2][2] = {16'h0, ifc.rdata[71:48]};
  assign act_cnt[0] = ifa.cnt;  assign act_cnt[1] = ifb.cnt;  assign act_cnt[2] = {16'h0, ifc.cnt};
  assign act_ord[0] = ifa.ord;  assign act_ord[1] = ifb.ord;  assign act_ord[2] = {16'h0, ifc.ord};
  assign act_comp[0] = ifa.comp; assign act_comp[1] = ifb.comp; assign act_comp[2] = ifc.comp;

  // Model: plain register arrays per instance, updated from the rules.
  int DW  [3] = '{40, 40, 24};
  int DEP [3] = '{16, 16, 8};
  int NR  [3] = '{2, 3, 3};
  bit BYP [3] = '{1'b0, 1'b1, 1'b0};
  logic [39:0] m [3][16];

  function automatic logic [39:0] msk(input int k);
    return 40'hFF_FFFF_FFFF >> (40 - DW[k]);
  endfunction

  function automatic logic [39:0] exp_rd(input int k, input int p);
    int a;
    a = int'(src[p]) % DEP[k];
    if (BYP[k] && we && !restart && a == int'(dst) % DEP[k])
      return wdata & msk(k);
    return m[k][a];
  endfunction

  always @(posedge clk) begin
    int d;
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        for (int i = 0; i < 16; i++) m[k][i] <= '0;
        m[k][0] <= 40'(INIT_DEF);
      end else if (restart) begin
        m[k][0] <= 40'(INIT_DEF);
        m[k][1] <= '0;
        m[k][2] <= '0;
      end else if (we) begin
        d = int'(dst) % DEP[k];
        m[k][d] <= wdata & msk(k);
        if (d == 0 && wdata[17:0] != m[k][0][17:0] && m[k][1] != msk(k))
          m[k][1] <= m[k][1] + 40'd1;
      end
    end
  end

  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        for (int p = 0; p < NR[k]; p++)
          chk($sformatf("model_rd%0d_%0d", k, p), act_rd[k][p], exp_rd(k, p));
        chk($sformatf("model_cnt%0d", k), act_cnt[k], m[k][1]);
        chk($sformatf("model_ord%0d", k), act_ord[k], m[k][2]);
        chk($sformatf("model_comp%0d", k), {39'h0, act_comp[k]},
            {39'h0, m[k][0][17:0] == GOAL_DEF});
      end
    end
  end

  task automatic sync();
    @(posedge clk); #2;
  endtask

  task automatic wr(input logic [3:0] a, input logic [39:0] d);
    we = 1'b1; dst = a; wdata = d;
    sync();
    we = 1'b0;
  endtask

  initial begin
    for (int p = 0; p < 3; p++) src[p] = '0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_board", act_rd[0][0], 40'h00_0002_3468);
    chk("rst_cnt", act_cnt[0], 40'h0);
    chk("rst_ord", act_ord[0], 40'h0);
    chk("rst_comp", {39'h0, act_comp[0]}, 40'h0);
    sync();
    for (int i = 1; i < 16; i++) begin
      src[0] = 4'(i);
      @(negedge clk);
      chk($sformatf("rst_reg%0d", i), act_rd[0][0], 40'h0);
      sync();
    end

    // Solved board: count and goal flag, then a same-value rewrite.
    wr(4'd5, 40'hA5);
    wr(4'd0, 40'h00_0000_A728);
    @(negedge clk);
    chk("goal_cnt", act_cnt[0], 40'h1);
    chk("goal_comp", {39'h0, act_comp[0]}, 40'h1);
    chk("goal_cnt_c", act_cnt[2], 40'h1);
    sync();
    wr(4'd0, 40'h00_0000_A728);
    @(negedge clk);
    chk("rewrite_cnt", act_cnt[0], 40'h1);
    sync();
    wr(4'd2, 40'h77);
    @(negedge clk);
    chk("ord_wr", act_ord[0], 40'h77);
    sync();

    // Saturation.
    wr(4'd1, 40'hFF_FFFF_FFFF);
    wr(4'd0, 40'h00_0002_3468);
    @(negedge clk);
    chk("sat_cnt", act_cnt[0], 40'hFF_FFFF_FFFF);
    chk("sat_cnt_c", act_cnt[2], 40'h00_00FF_FFFF);
    sync();

    // Restart wins over a board write; reg5 survives.
    src[0] = 4'd5; src[1] = 4'd0;
    restart = 1'b1; we = 1'b1; dst = 4'd0; wdata = 40'h00_0000_A728;
    sync();
    restart = 1'b0; we = 1'b0;
    @(negedge clk);
    chk("rs_reg5", act_rd[0][0], 40'hA5);
    chk("rs_board", act_rd[0][1], 40'h00_0002_3468);
    chk("rs_cnt", act_cnt[0], 40'h0);
    chk("rs_ord", act_ord[0], 40'h0);
    chk("rs_comp", {39'h0, act_comp[0]}, 40'h0);
    sync();

    // Same-cycle bypass vs. registered read.
    src[0] = 4'd7; src[1] = 4'd7; src[2] = 4'd0;
    we = 1'b1; dst = 4'd7; wdata = 40'h1234;
    @(negedge clk);
    chk("byp_p0", act_rd[1][0], 40'h1234);
    chk("byp_p1", act_rd[1][1], 40'h1234);
    chk("byp_p2", act_rd[1][2], 40'h00_0002_3468);
    chk("nobyp_p0", act_rd[2][0], 40'h0);
    chk("nobyp_p1", act_rd[2][1], 40'h0);
    sync();
    we = 1'b0;
    @(negedge clk);
    chk("lat1_c", act_rd[2][0], 40'h1234);
    sync();

    // No forwarding while restart is high.
    restart = 1'b1; we = 1'b1; dst = 4'd7; wdata = 40'h9999;
    @(negedge clk);
    chk("byp_rs", act_rd[1][0], 40'h1234);
    sync();
    restart = 1'b0; we = 1'b0;
    @(negedge clk);
    chk("byp_rs_kept", act_rd[1][0], 40'h1234);
    sync();

    // Upper board bits are stored but do not count as a move.
    src[1] = 4'd0;
    wr(4'd0, 40'hAB_0002_3468);
    @(negedge clk);
    chk("upper_rd", act_rd[0][1], 40'hAB_0002_3468);
    chk("upper_cnt", act_cnt[0], 40'h0);
    sync();

    // Five differing boards.
    restart = 1'b1; sync(); restart = 1'b0;
    wr(4'd0, 40'h00_0000_A728);
    wr(4'd0, 40'h00_0002_3468);
    wr(4'd0, 40'h1);
    wr(4'd0, 40'h2);
    wr(4'd0, 40'h00_0000_A728);
    @(negedge clk);
    chk("cnt5_c", act_cnt[2], 40'h5);
    chk("cnt5_a", act_cnt[0], 40'h5);
    chk("cnt5_comp", {39'h0, act_comp[2]}, 40'h1);
    sync();

    // Write/readback sweep over the 8-entry instance.
    for (int i = 0; i < 8; i++) wr(4'(i), 40'h5A_0000 + 40'(i) * 40'h1_0101);
    for (int i = 0; i < 8; i++) begin
      src[0] = 4'(i);
      @(negedge clk);
      chk($sformatf("sweep_c%0d", i), act_rd[2][0], 40'h5A_0000 + 40'(i) * 40'h1_0101);
      sync();
    end

    // Mid-stream reset: write during reset dropped, first write after it lands.
    rst_n = 1'b0; we = 1'b1; dst = 4'd3; wdata = 40'hEE;
    sync();
    rst_n = 1'b1; wdata = 40'hFF;
    sync();
    we = 1'b0; src[0] = 4'd3;
    @(negedge clk);
    chk("post_rst_wr", act_rd[0][0], 40'hFF);
    chk("post_rst_cnt", act_cnt[0], 40'h0);
    sync();
    sync();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
